// File: rtl/juiz_jogada.sv
// juiz_jogada - judge for a single player move in the piano game.
//
// Latches the expected note and hold time, waits for a key press, measures
// how long the key is held in metronome ticks and reports whether the note
// and the duration were right. A saturating error budget drives perdeu.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low
//   inicia         start a judgement (accepted only when idle and perdeu=0)
//   nota_esperada  expected key index, latched on accepted inicia
//   tempo_esperado expected hold time in ticks, latched on accepted inicia
//   tick           one-cycle metronome subdivision pulse
//   botoes         debounced key levels
//   zera_erros     synchronous clear of the error count (wins over increment)
//   ocupado        high while a judgement is in progress
//   pronto         one-cycle pulse, result flags valid
//   nota_correta   captured key matches the expected one
//   tempo_correto  hold time within TOLERANCIA of the expected one
//   tempo_baixo    hold time shorter than the tolerance window
//   estourou       no key pressed within TIMEOUT ticks
//   erros          saturating error count
//   perdeu         erros reached MAX_ERROS
//   nota_tocada    captured key index
//
// Optional feature: define JUIZ_MULTITECLA_EN to mark a move wrong whenever
// more than one key is down at capture or at any cycle while holding.

module juiz_jogada #(
    parameter int NUM_BOTOES  = 13,
    parameter int MAX_DURACAO = 63,
    parameter int TOLERANCIA  = 1,
    parameter int TIMEOUT     = 16,
    parameter int MAX_ERROS   = 3,
    localparam int NW = $clog2(NUM_BOTOES),
    localparam int DW = $clog2(MAX_DURACAO + 1),
    localparam int EW = $clog2(MAX_ERROS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inicia,
    input  logic [NW-1:0]         nota_esperada,
    input  logic [DW-1:0]         tempo_esperado,
    input  logic                  tick,
    input  logic [NUM_BOTOES-1:0] botoes,
    input  logic                  zera_erros,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  nota_correta,
    output logic                  tempo_correto,
    output logic                  tempo_baixo,
    output logic                  estourou,
    output logic [EW-1:0]         erros,
    output logic                  perdeu,
    output logic [NW-1:0]         nota_tocada
);

    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {OCIOSO, ESPERA, SEGURA, AVALIA} estado_t;

    estado_t         estado, prox_estado;
    logic [NW-1:0]   nota_esp_q;
    logic [DW-1:0]   tempo_esp_q;
    logic [DW-1:0]   duracao;
    logic [WW-1:0]   cont_espera;
    logic [NW-1:0]   indice;
    logic            alguma_tecla;
    logic            aceita;
    logic            espera_fim;
    logic [DW:0]     diferenca;
    logic [DW:0]     limite_baixo;
    logic            limite_negativo;
    logic            nota_ok;
    logic            tempo_ok;
    logic            baixo;
    logic            erro;

    assign alguma_tecla = |botoes;
    assign aceita       = (estado == OCIOSO) && inicia && !perdeu;
    assign espera_fim   = (cont_espera == WW'(TIMEOUT - 1));
    assign ocupado      = (estado != OCIOSO);
    assign perdeu       = (erros == EW'(MAX_ERROS));

    // Priority encoder: the lowest pressed key index wins.
    always_comb begin
        indice = '0;
        for (int i = NUM_BOTOES - 1; i >= 0; i--) begin
            if (botoes[i]) indice = NW'(i);
        end
    end

    // Evaluation arithmetic is done one bit wider so the lower edge of the
    // window can detect underflow when tempo_esperado < TOLERANCIA.
    always_comb begin
        diferenca = (duracao >= tempo_esp_q) ? ({1'b0, duracao} - {1'b0, tempo_esp_q})
                                             : ({1'b0, tempo_esp_q} - {1'b0, duracao});
        limite_negativo = ({1'b0, tempo_esp_q} < (DW+1)'(TOLERANCIA));
        limite_baixo    = {1'b0, tempo_esp_q} - (DW+1)'(TOLERANCIA);
        tempo_ok = !estourou && (diferenca <= (DW+1)'(TOLERANCIA));
        baixo    = !estourou && !limite_negativo && ({1'b0, duracao} < limite_baixo);
    end

`ifdef JUIZ_MULTITECLA_EN
    logic multi_q;
    logic varias;

    // More than one bit set: clearing the lowest set bit leaves something.
    assign varias  = |(botoes & (botoes - NUM_BOTOES'(1)));
    assign nota_ok = !estourou && !multi_q && (nota_tocada == nota_esp_q);

    // Sticky multi-key flag, sampled at capture and through the hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            multi_q <= 1'b0;
        end else if (aceita) begin
            multi_q <= 1'b0;
        end else if ((estado == ESPERA || estado == SEGURA) && varias) begin
            multi_q <= 1'b1;
        end
    end
`else
    assign nota_ok = !estourou && (nota_tocada == nota_esp_q);
`endif

    assign erro = !(nota_ok && tempo_ok);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    // Next-state logic. A press in ESPERA takes precedence over a timeout
    // tick in the same cycle; a release in SEGURA ignores a coincident tick.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO: if (aceita) prox_estado = ESPERA;
            ESPERA: begin
                if (alguma_tecla)           prox_estado = SEGURA;
                else if (tick && espera_fim) prox_estado = AVALIA;
            end
            SEGURA: if (!alguma_tecla) prox_estado = AVALIA;
            AVALIA: prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // Datapath: expected values, counters, captured key and result flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nota_esp_q    <= '0;
            tempo_esp_q   <= '0;
            duracao       <= '0;
            cont_espera   <= '0;
            nota_tocada   <= '0;
            estourou      <= 1'b0;
            nota_correta  <= 1'b0;
            tempo_correto <= 1'b0;
            tempo_baixo   <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            pronto <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        nota_esp_q    <= nota_esperada;
                        tempo_esp_q   <= tempo_esperado;
                        duracao       <= '0;
                        cont_espera   <= '0;
                        nota_tocada   <= '0;
                        estourou      <= 1'b0;
                        nota_correta  <= 1'b0;
                        tempo_correto <= 1'b0;
                        tempo_baixo   <= 1'b0;
                    end
                end
                ESPERA: begin
                    if (alguma_tecla) begin
                        nota_tocada <= indice;
                        duracao     <= '0;
                    end else if (tick) begin
                        cont_espera <= cont_espera + WW'(1);
                        if (espera_fim) estourou <= 1'b1;
                    end
                end
                SEGURA: begin
                    if (alguma_tecla && tick && duracao != DW'(MAX_DURACAO)) begin
                        duracao <= duracao + DW'(1);
                    end
                end
                AVALIA: begin
                    nota_correta  <= nota_ok;
                    tempo_correto <= tempo_ok;
                    tempo_baixo   <= baixo;
                    pronto        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Saturating error budget; a clear request overrides a same-cycle error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            erros <= '0;
        end else if (zera_erros) begin
            erros <= '0;
        end else if (estado == AVALIA && erro && !perdeu) begin
            erros <= erros + EW'(1);
        end
    end

endmodule

// File: tb/tb_juiz_jogada.sv
// tb_juiz_jogada - directed self-checking bench for juiz_jogada.
// Drives moves with hand-computed expectations and checks flags, timing of
// pronto/ocupado, the error budget, timeout, saturation and reset abort.

module tb_juiz_jogada;

    logic        clock;
    logic        reset;
    logic        inicia;
    logic [3:0]  nota_esperada;
    logic [5:0]  tempo_esperado;
    logic        tick;
    logic [12:0] botoes;
    logic        zera_erros;
    logic        ocupado;
    logic        pronto;
    logic        nota_correta;
    logic        tempo_correto;
    logic        tempo_baixo;
    logic        estourou;
    logic [1:0]  erros;
    logic        perdeu;
    logic [3:0]  nota_tocada;

    int total = 0;
    int bad   = 0;

`ifdef JUIZ_MULTITECLA_EN
    localparam logic MULTI_NOTA_OK = 1'b0;
    localparam int   MULTI_ERROS   = 1;
`else
    localparam logic MULTI_NOTA_OK = 1'b1;
    localparam int   MULTI_ERROS   = 0;
`endif

    juiz_jogada dut (
        .clock          (clock),
        .reset          (reset),
        .inicia         (inicia),
        .nota_esperada  (nota_esperada),
        .tempo_esperado (tempo_esperado),
        .tick           (tick),
        .botoes         (botoes),
        .zera_erros     (zera_erros),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .nota_correta   (nota_correta),
        .tempo_correto  (tempo_correto),
        .tempo_baixo    (tempo_baixo),
        .estourou       (estourou),
        .erros          (erros),
        .perdeu         (perdeu),
        .nota_tocada    (nota_tocada)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock and settle just after the rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    // Plays one full move: start, press keys, hold for n ticks (switching
    // to keys_depois after the first tick), release, and check the pronto
    // timing. Optionally asserts zera_erros during the AVALIA cycle.
    task automatic jogada(input logic [3:0] nota, input logic [5:0] tempo,
                          input logic [12:0] keys, input logic [12:0] keys_depois,
                          input int n, input logic zera_no_avalia);
        nota_esperada  = nota;
        tempo_esperado = tempo;
        inicia = 1'b1;
        cyc();
        inicia = 1'b0;
        nota_esperada  = ~nota;
        tempo_esperado = ~tempo;
        check("ocupado_apos_inicia", ocupado, 1);
        botoes = keys;
        cyc();
        for (int i = 0; i < n; i++) begin
            pulse_tick();
            botoes = keys_depois;
        end
        botoes = 13'd0;
        cyc();
        check("pronto_cedo", pronto, 0);
        zera_erros = zera_no_avalia;
        cyc();
        zera_erros = 1'b0;
        check("pronto_pulso", pronto, 1);
        check("ocupado_no_pronto", ocupado, 0);
    endtask

    task automatic jogada_sem_tecla();
        nota_esperada  = 4'd4;
        tempo_esperado = 6'd4;
        inicia = 1'b1;
        cyc();
        inicia = 1'b0;
        for (int i = 0; i < 15; i++) begin
            pulse_tick();
            if (i == 3) begin
                inicia = 1'b1;
                cyc();
                inicia = 1'b0;
            end
        end
        check("espera_ainda_ocupado", ocupado, 1);
        check("espera_sem_estouro", estourou, 0);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("timeout_pronto_cedo", pronto, 0);
        cyc();
        check("timeout_pronto", pronto, 1);
        check("timeout_estourou", estourou, 1);
        check("timeout_nota", nota_correta, 0);
        check("timeout_tempo", tempo_correto, 0);
    endtask

    task automatic zera();
        zera_erros = 1'b1;
        cyc();
        zera_erros = 1'b0;
        check("zera_erros", erros, 0);
        check("zera_perdeu", perdeu, 0);
    endtask

    task automatic applyStimulus();
        // Reset state
        reset = 1'b0;
        inicia = 1'b0;
        nota_esperada = 4'd0;
        tempo_esperado = 6'd0;
        tick = 1'b0;
        botoes = 13'd0;
        zera_erros = 1'b0;
        cyc();
        cyc();
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_erros", erros, 0);
        check("rst_perdeu", perdeu, 0);
        check("rst_nota_tocada", nota_tocada, 0);
        check("rst_estourou", estourou, 0);
        reset = 1'b1;
        cyc();

        // Exact hold
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 4, 1'b0);
        check("a_nota_tocada", nota_tocada, 5);
        check("a_nota", nota_correta, 1);
        check("a_tempo", tempo_correto, 1);
        check("a_baixo", tempo_baixo, 0);
        check("a_estourou", estourou, 0);
        check("a_erros", erros, 0);
        cyc();
        check("a_pronto_um_ciclo", pronto, 0);
        check("a_flags_mantidas", nota_correta, 1);

        // Tolerance edges
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 3, 1'b0);
        check("t3_tempo", tempo_correto, 1);
        check("t3_baixo", tempo_baixo, 0);
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 5, 1'b0);
        check("t5_tempo", tempo_correto, 1);
        check("t5_erros", erros, 0);

        // Window lower edge underflows for tempo 0
        jogada(4'd0, 6'd0, 13'd1, 13'd1, 0, 1'b0);
        check("t0_tempo", tempo_correto, 1);
        check("t0_baixo", tempo_baixo, 0);
        check("t0_erros", erros, 0);

        // Too short and too long
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 2, 1'b0);
        check("curto_tempo", tempo_correto, 0);
        check("curto_baixo", tempo_baixo, 1);
        check("curto_nota", nota_correta, 1);
        check("curto_erros", erros, 1);
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 6, 1'b0);
        check("longo_tempo", tempo_correto, 0);
        check("longo_baixo", tempo_baixo, 0);
        check("longo_erros", erros, 2);
        zera();

        // Changing keys while holding keeps the captured one
        jogada(4'd3, 6'd4, 13'd1 << 3, 13'd1 << 1, 4, 1'b0);
        check("troca_nota_tocada", nota_tocada, 3);
        check("troca_nota", nota_correta, 1);
        check("troca_erros", erros, 0);

        // Two keys at capture
        jogada(4'd2, 6'd4, (13'd1 << 2) | (13'd1 << 7), (13'd1 << 2) | (13'd1 << 7), 4, 1'b0);
        check("multi_nota_tocada", nota_tocada, 2);
        check("multi_nota", nota_correta, MULTI_NOTA_OK);
        check("multi_tempo", tempo_correto, 1);
        check("multi_erros", erros, MULTI_ERROS);
        zera();

        // Duration saturation at 63
        jogada(4'd12, 6'd63, 13'd1 << 12, 13'd1 << 12, 70, 1'b0);
        check("sat_nota", nota_correta, 1);
        check("sat_tempo", tempo_correto, 1);
        check("sat_baixo", tempo_baixo, 0);
        check("sat_erros", erros, 0);

        // Clear coinciding with an error in AVALIA
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 2, 1'b0);
        check("pre_zera_erros", erros, 1);
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 2, 1'b1);
        check("zera_av_tempo", tempo_correto, 0);
        check("zera_av_erros", erros, 0);

        // Timeouts build up to perdeu
        jogada_sem_tecla();
        check("to1_erros", erros, 1);
        check("to1_perdeu", perdeu, 0);
        jogada_sem_tecla();
        check("to2_erros", erros, 2);
        jogada_sem_tecla();
        check("to3_erros", erros, 3);
        check("to3_perdeu", perdeu, 1);
        inicia = 1'b1;
        cyc();
        inicia = 1'b0;
        check("perdeu_ignora_inicia", ocupado, 0);
        cyc();
        check("perdeu_ainda_ocioso", ocupado, 0);
        zera();

        // Reset in the middle of a hold aborts everything
        jogada(4'd5, 6'd4, 13'd1 << 5, 13'd1 << 5, 2, 1'b0);
        check("pre_reset_erros", erros, 1);
        nota_esperada = 4'd6;
        tempo_esperado = 6'd4;
        inicia = 1'b1;
        cyc();
        inicia = 1'b0;
        botoes = 13'd1 << 6;
        cyc();
        pulse_tick();
        check("pre_reset_ocupado", ocupado, 1);
        reset = 1'b0;
        #1;
        check("reset_ocupado", ocupado, 0);
        check("reset_erros", erros, 0);
        check("reset_nota_tocada", nota_tocada, 0);
        check("reset_pronto", pronto, 0);
        botoes = 13'd0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("reset_sem_pronto", pronto, 0);
        end
    endtask

    initial begin
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
